// File: rtl/aes_round_key_gen.sv
// aes_round_key_gen
//   Sequential AES-128 round-key producer for the enc/dec round datapath.
//   Enc=1 streams rk0..rk10. Enc=0 first expands forward to rk10 (10 cycles),
//   then streams rk10..rk0 using the inverse key schedule. One key is
//   transferred per Key_valid/Key_ready handshake.
//
//   Optional feature macro: AES_KEYGEN_CACHE_EN
//     When defined, the last expanded Cipher_key and its rk10 are cached, so a
//     decrypt Start with the same key skips the 10-cycle expansion.
//
// Ports
//   Clk         in   1    clock, rising edge
//   Rst         in   1    synchronous active-high reset
//   Start       in   1    load Cipher_key/Enc (sampled only when idle)
//   Enc         in   1    1 = forward key order, 0 = reverse order
//   Cipher_key  in   128  AES-128 key, [127:96] = w0
//   Key_ready   in   1    consumer accepts Key this cycle
//   Key_valid   out  1    Key/Round/Last valid
//   Key         out  128  round key
//   Round       out  4    schedule index of Key (0..10)
//   Last        out  1    final key of the stream
//   Busy        out  1    from accepted Start until final handshake
//
// FSM states
//   state    | meaning
//   S_IDLE   | waiting for Start
//   S_EXPAND | decrypt pre-expansion, one forward step per cycle up to rk10
//   S_STREAM | presenting keys, one step per handshake

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_round_key_gen #(
  parameter int NR       = 10,
  parameter int KEY_BITS = `AES_BLOCK_SIZE
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Enc,
  input  logic [KEY_BITS-1:0] Cipher_key,
  input  logic                Key_ready,
  output logic                Key_valid,
  output logic [KEY_BITS-1:0] Key,
  output logic [3:0]          Round,
  output logic                Last,
  output logic                Busy
);

  generate
    if (NR != 10 || KEY_BITS != 128) begin : g_param_check
      $error("aes_round_key_gen supports AES-128 only (NR=10, KEY_BITS=128)");
    end
  endgenerate

  localparam logic [3:0] RND_LAST = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_STREAM} state_t;

  state_t state;
  logic   enc_q;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as affine(x^254); x^254 is the field inverse and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One shared SubWord serves both directions: the forward step substitutes
  // w3, the inverse step substitutes the recovered w3' = w3 ^ w2.
  logic [31:0] w0, w1, w2, w3;
  logic        inv_step;
  logic [31:0] sub_src, rot_word, sub_word, t_word;
  logic [3:0]  rcon_idx;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] i0, i1, i2, i3;
  logic [127:0] fwd_key, inv_key;

  assign {w0, w1, w2, w3} = Key;
  assign inv_step = (state == S_STREAM) && !enc_q;
  assign sub_src  = inv_step ? (w3 ^ w2) : w3;
  assign rot_word = {sub_src[23:0], sub_src[31:24]};
  assign rcon_idx = inv_step ? Round : Round + 4'd1;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_word[8*g +: 8] = sbox(rot_word[8*g +: 8]);
  end

  assign t_word = sub_word ^ {rcon(rcon_idx), 24'h000000};

  assign f0 = w0 ^ t_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};

  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ t_word;
  assign inv_key = {i0, i1, i2, i3};

`ifdef AES_KEYGEN_CACHE_EN
  logic [127:0] cache_key;
  logic [127:0] cache_rk10;
  logic         cache_valid;
  logic         cache_hit;
  assign cache_hit = cache_valid && (Cipher_key == cache_key);
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      enc_q     <= 1'b0;
      Key_valid <= 1'b0;
      Key       <= '0;
      Round     <= 4'd0;
      Last      <= 1'b0;
      Busy      <= 1'b0;
`ifdef AES_KEYGEN_CACHE_EN
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            Busy  <= 1'b1;
            enc_q <= Enc;
            Key   <= Cipher_key;
            Round <= 4'd0;
            Last  <= 1'b0;
            if (Enc) begin
              state     <= S_STREAM;
              Key_valid <= 1'b1;
            end
`ifdef AES_KEYGEN_CACHE_EN
            else if (cache_hit) begin
              Key       <= cache_rk10;
              Round     <= RND_LAST;
              state     <= S_STREAM;
              Key_valid <= 1'b1;
            end
`endif
            else begin
              state     <= S_EXPAND;
              Key_valid <= 1'b0;
`ifdef AES_KEYGEN_CACHE_EN
              // key captured now, entry becomes valid once rk10 is known
              cache_key   <= Cipher_key;
              cache_valid <= 1'b0;
`endif
            end
          end
        end

        S_EXPAND: begin
          Key   <= fwd_key;
          Round <= Round + 4'd1;
          if (Round == RND_LAST - 4'd1) begin
            state     <= S_STREAM;
            Key_valid <= 1'b1;
`ifdef AES_KEYGEN_CACHE_EN
            cache_rk10  <= fwd_key;
            cache_valid <= 1'b1;
`endif
          end
        end

        S_STREAM: begin
          if (Key_valid && Key_ready) begin
            if (Last) begin
              state     <= S_IDLE;
              Key_valid <= 1'b0;
              Last      <= 1'b0;
              Busy      <= 1'b0;
            end else if (enc_q) begin
              Key   <= fwd_key;
              Round <= Round + 4'd1;
              Last  <= (Round == RND_LAST - 4'd1);
            end else begin
              Key   <= inv_key;
              Round <= Round - 4'd1;
              Last  <= (Round == 4'd1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
